// File: rtl/aes_encrypt_round_engine.sv
// Iterative AES-128 encryption engine: round 0 on accept, then one round per clock.
// Also holds the S-box, SubBytes and key-expansion helpers used by the engine.

module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
  always_comb begin
    x2   = gf_mul(value, value);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)), gf_mul(gf_mul(x32, x64), x128));
    subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_sub_bytes (
  input  logic [127:0] state,
  output logic [127:0] result
);
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .value (state[8*i +: 8]),
      .subst (result[8*i +: 8])
    );
  end
endmodule

module aes_key_generation (
  input  logic [127:0]  key,
  output logic [1407:0] round_keys
);
  function automatic logic [7:0] rcon(input int r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  logic [31:0] w [44];

  assign w[0] = key[127:96];
  assign w[1] = key[95:64];
  assign w[2] = key[63:32];
  assign w[3] = key[31:0];

  for (genvar r = 1; r <= 10; r++) begin : g_round
    logic [31:0] rot;
    logic [31:0] sub;
    assign rot = {w[4*r-1][23:0], w[4*r-1][31:24]};
    for (genvar j = 0; j < 4; j++) begin : g_sub
      aes_sbox u_sbox (
        .value (rot[8*j +: 8]),
        .subst (sub[8*j +: 8])
      );
    end
    assign w[4*r]   = w[4*r-4] ^ sub ^ {rcon(r), 24'h0};
    assign w[4*r+1] = w[4*r-3] ^ w[4*r];
    assign w[4*r+2] = w[4*r-2] ^ w[4*r+1];
    assign w[4*r+3] = w[4*r-1] ^ w[4*r+2];
  end

  // Round key r occupies round_keys[128*r +: 128].
  for (genvar r = 0; r <= 10; r++) begin : g_out
    assign round_keys[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end
endmodule

module aes_encrypt_round_engine #(
  parameter bit CLEAR_DATA_ON_RST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_key,
  input  logic [127:0] i_plaintext,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_ciphertext,
  output logic         o_busy
);
  typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;

  logic [1407:0] round_keys;
  logic [127:0]  rk_arr [16];
  logic [127:0]  sb, sr, mc, round_out, rk;
  logic          accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i sits at [127-8i -: 8]; byte index = row + 4*col.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  aes_key_generation u_key_gen (
    .key        (key_q),
    .round_keys (round_keys)
  );

  aes_sub_bytes u_sub_bytes (
    .state  (state_q),
    .result (sb)
  );

  for (genvar i = 0; i < 16; i++) begin : g_rk
    if (i <= 10) begin : g_valid
      assign rk_arr[i] = round_keys[128*i +: 128];
    end else begin : g_unused
      assign rk_arr[i] = '0;
    end
  end

  assign rk        = rk_arr[round_q];
  assign sr        = shift_rows(sb);
  assign mc        = mix_columns(sr);
  assign round_out = ((round_q == 4'd10) ? sr : mc) ^ rk;

  assign o_in_ready   = i_rst_n & ((fsm_q == StIdle) | ((fsm_q == StDone) & i_out_ready));
  assign o_out_valid  = i_rst_n & (fsm_q == StDone);
  assign o_busy       = i_rst_n & (fsm_q == StRun);
  assign o_ciphertext = ct_q;
  assign accept       = i_in_valid & o_in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    key_d   = key_q;
    ct_d    = ct_q;
    unique case (fsm_q)
      StIdle: begin
        if (accept) begin
          key_d   = i_key;
          state_d = i_plaintext ^ i_key;
          round_d = 4'd1;
          fsm_d   = StRun;
        end
      end
      StRun: begin
        state_d = round_out;
        if (round_q == 4'd10) begin
          ct_d    = round_out;
          round_d = 4'd0;
          fsm_d   = StDone;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      StDone: begin
        if (accept) begin
          key_d   = i_key;
          state_d = i_plaintext ^ i_key;
          round_d = 4'd1;
          fsm_d   = StRun;
        end else if (i_out_ready) begin
          fsm_d = StIdle;
        end
      end
      default: begin
        fsm_d   = StIdle;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fsm_q   <= StIdle;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n && CLEAR_DATA_ON_RST) begin
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  round_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n) round_q <= 4'd10);
endmodule

// File: tb/tb_aes_encrypt_round_engine.sv
// Directed bench for aes_encrypt_round_engine using FIPS-197 vectors and an output scoreboard.

module tb_aes_encrypt_round_engine;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] pt;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;
  logic [127:0] exp_ct;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int n_out = 0;
  bit lat_checked = 1'b0;
  logic [127:0] exp_q [$];
  int acc_q [$];
  int out_cyc [$];

  aes_encrypt_round_engine #(
    .CLEAR_DATA_ON_RST (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_key        (key),
    .i_plaintext  (pt),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_ciphertext (ct),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_ct);
        acc_q.push_back(cyc + 1);
      end
      if (out_valid && !lat_checked) begin
        lat_checked = 1'b1;
        if (acc_q.size() != 0) chk("latency", 128'(cyc - acc_q[0]), 128'd10);
        else chk("valid_without_accept", 128'(acc_q.size()), 128'd1);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          chk("ciphertext", ct, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        out_cyc.push_back(cyc);
        n_out++;
        lat_checked = 1'b0;
      end
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] p, input logic [127:0] e);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    key      = k;
    pt       = p;
    exp_ct   = e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 60);
    chk("accept_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int i = 0; i < 60 && n_out < target; i++) @(negedge clk);
    chk("out_timeout", 128'(n_out >= target), 128'd1);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    pt        = '0;
    exp_ct    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ct, 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'd1);

    // App.B single block with latency check
    out_ready = 1'b1;
    send(KB, PB, CB);
    @(negedge clk);
    chk("run_busy", 128'(busy), 128'd1);
    chk("run_in_ready", 128'(in_ready), 128'd0);
    wait_out(1);

    // App.C.1 single block
    send(KC, PC, CC);
    wait_out(2);

    // Backpressure in DONE with ignored input
    out_ready = 1'b0;
    send(KB, PB, CB);
    for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
    chk("bp_valid_seen", 128'(out_valid), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    key      = KC;
    pt       = PC;
    exp_ct   = CC;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_ct_stable", ct, CB);
      chk("bp_valid_held", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_out(3);
    repeat (15) @(negedge clk);
    chk("bp_no_extra_out", 128'(n_out), 128'd3);
    chk("bp_valid_low", 128'(out_valid), 128'd0);
    chk("bp_sb_empty", 128'(exp_q.size()), 128'd0);

    // Back-to-back blocks
    send(KB, PB, CB);
    send(KC, PC, CC);
    wait_out(5);
    chk("b2b_spacing", 128'(out_cyc[4] - out_cyc[3]), 128'd11);

    // Inputs change during RUN
    send(KC, PC, CC);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("kc_busy", 128'(busy), 128'd1);
    end
    wait_out(6);

    // Reset at round 5 aborts the block
    send(KB, PB, CB);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    lat_checked = 1'b0;
    base = n_out;
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    chk("post_rst_busy", 128'(busy), 128'd0);
    chk("post_rst_out_valid", 128'(out_valid), 128'd0);
    chk("post_rst_ct_clear", ct, 128'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_out", 128'(n_out), 128'(base));
    send(KC, PC, CC);
    wait_out(base + 1);

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
